// File: rtl/dram_mport_bist.sv
// Multi-port distributed RAM: one synchronous write port, NUM_RD asynchronous read ports,
// and a fill/check self-test sequencer that can be bypassed by a manual access mode.
module dram_mport_bist #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 1,
  parameter int NUM_RD = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       manual,
  input  logic                       fault_inj,
  input  logic                       man_we,
  input  logic [ADDR_W-1:0]          man_waddr,
  input  logic [DATA_W-1:0]          man_wdata,
  input  logic [NUM_RD*ADDR_W-1:0]   man_raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [15:0]                err_count,
  output logic [1:0]                 dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                ph_q, ph_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [15:0]         err_q, err_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                idle_like;
  logic                man_sel;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic [ADDR_W-1:0]   raddr [NUM_RD];
  logic [15:0]         n_err;
  logic [16:0]         err_sum;

  // Address bits are repeated across the word, then the whole word is flipped by phase.
  function automatic logic [DATA_W-1:0] exp_word(input logic [ADDR_W-1:0] a, input logic ph);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = a[i % ADDR_W] ^ ph;
    end
    return r;
  endfunction

  always_comb begin
    idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    man_sel   = manual && idle_like;
    we        = man_sel ? man_we : (state_q == S_FILL);
    waddr     = man_sel ? man_waddr : cnt_q;
    wdata     = exp_word(cnt_q, ph_q);
    if (fault_inj && !ph_q && (cnt_q == '0)) begin
      wdata = ~wdata;
    end
    if (man_sel) begin
      wdata = man_wdata;
    end
    for (int p = 0; p < NUM_RD; p++) begin
      raddr[p] = man_sel ? man_raddr[p*ADDR_W +: ADDR_W] : cnt_q + ADDR_W'(p);
    end
  end

  // Array has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rdata[p*DATA_W +: DATA_W] = mem_q[raddr[p]];
    end
  end

  always_comb begin
    n_err = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rdata[p*DATA_W +: DATA_W] != exp_word(cnt_q + ADDR_W'(p), ph_q)) begin
        n_err = n_err + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ph_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    err_sum = {1'b0, err_q} + {1'b0, n_err};
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !manual) begin
          state_d = S_FILL;
          ph_d    = 1'b0;
          cnt_d   = '0;
          err_d   = '0;
        end
      end
      S_FILL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        cnt_d = cnt_q + 1'b1;
        err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if (cnt_q == '1) begin
          if (!ph_q) begin
            state_d = S_FILL;
            ph_d    = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q == S_FILL) || (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dram_mport_bist.sv
// Bench for dram_mport_bist: timeline model of the default instance checked every cycle,
// plus directed literal checks on both a default and a 4x4x3 instance.
module tb_dram_mport_bist;

  localparam int D = 64;

  logic        clk;
  int          n_tests, n_fail;

  logic        rst_n_a, start_a, manual_a, fi_a, we_a;
  logic [5:0]  waddr_a;
  logic [0:0]  wdata_a;
  logic [47:0] raddr_a;
  logic [7:0]  rdata_a;
  logic        busy_a, done_a, pass_a;
  logic [15:0] err_a;
  logic [1:0]  st_a;

  logic        rst_n_b, start_b, manual_b, fi_b, we_b;
  logic [3:0]  waddr_b, wdata_b;
  logic [11:0] raddr_b, rdata_b;
  logic        busy_b, done_b, pass_b;
  logic [15:0] err_b;
  logic [1:0]  st_b;

  dram_mport_bist dut_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .manual(manual_a), .fault_inj(fi_a),
    .man_we(we_a), .man_waddr(waddr_a), .man_wdata(wdata_a), .man_raddr(raddr_a),
    .rdata(rdata_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .dbg_state(st_a)
  );

  dram_mport_bist #(.ADDR_W(4), .DATA_W(4), .NUM_RD(3)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .manual(manual_b), .fault_inj(fi_b),
    .man_we(we_b), .man_waddr(waddr_b), .man_wdata(wdata_b), .man_raddr(raddr_b),
    .rdata(rdata_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .dbg_state(st_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int bench_exp(input int a, input int ph);
    return (a & 1) ^ ph;
  endfunction

  // Model of the default instance: a BIST run is a 4*D-cycle timeline split into
  // fill ph0 / check ph0 / fill ph1 / check ph1 quarters.
  bit m_busy, m_done;
  int m_t, m_err;
  int m_mem [D];
  bit m_vld [D];

  always @(posedge clk or negedge rst_n_a) begin
    int seg, k, ph, errs, a;
    if (!rst_n_a) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_t    <= 0;
      m_err  <= 0;
    end else if (!m_busy && manual_a) begin
      if (we_a) begin
        m_mem[waddr_a] <= int'(wdata_a);
        m_vld[waddr_a] <= 1'b1;
      end
    end else if (m_busy) begin
      seg  = m_t / D;
      k    = m_t % D;
      ph   = seg / 2;
      errs = 0;
      if (seg % 2 == 0) begin
        m_mem[k] <= bench_exp(k, ph) ^ ((fi_a && ph == 0 && k == 0) ? 1 : 0);
        m_vld[k] <= 1'b1;
      end else begin
        for (int p = 0; p < 8; p++) begin
          a = (k + p) % D;
          if (m_mem[a] != bench_exp(a, ph)) errs++;
        end
        m_err <= (m_err + errs > 65535) ? 65535 : m_err + errs;
      end
      m_t <= m_t + 1;
      if (m_t == 4*D - 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end
    end else if (start_a) begin
      m_busy <= 1'b1;
      m_t    <= 0;
      m_err  <= 0;
      m_done <= 1'b0;
    end
  end

  // scoreboard compare, every cycle on the falling edge
  always @(negedge clk) begin
    int addr;
    check("busy", busy_a, m_busy);
    check("done", done_a, m_done);
    check("pass", pass_a, (m_done && m_err == 0));
    check("err_count", err_a, m_err);
    for (int p = 0; p < 8; p++) begin
      if (!m_busy && manual_a) addr = int'(raddr_a[p*6 +: 6]);
      else if (m_busy)         addr = ((m_t % D) + p) % D;
      else                     addr = p;
      if (m_vld[addr]) check($sformatf("rdata_p%0d", p), rdata_a[p], m_mem[addr]);
    end
  end

  // drivers
  task automatic run_a(input bit fi, input bit poke, output int cyc);
    fi_a    = fi;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    cyc = 0;
    while (busy_a && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      if (poke && cyc == 50) begin
        start_a = 1'b1; manual_a = 1'b1; we_a = 1'b1; waddr_a = 6'd3; wdata_a = 1'b1;
      end
      if (poke && cyc == 55) begin
        start_a = 1'b0; manual_a = 1'b0; we_a = 1'b0;
      end
    end
    fi_a = 1'b0;
  endtask

  task automatic run_b(input bit fi, output int cyc);
    fi_b    = fi;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    cyc = 0;
    while (busy_b && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    fi_b = 1'b0;
  endtask

  initial begin
    int cyc;
    n_tests = 0; n_fail = 0;
    rst_n_a = 1'b0; start_a = 1'b0; manual_a = 1'b0; fi_a = 1'b0; we_a = 1'b0;
    waddr_a = '0; wdata_a = '0; raddr_a = '0;
    rst_n_b = 1'b0; start_b = 1'b0; manual_b = 1'b0; fi_b = 1'b0; we_b = 1'b0;
    waddr_b = '0; wdata_b = '0; raddr_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy_a, 1'b0);
    check("reset_done", done_a, 1'b0);
    check("reset_err", err_a, 16'd0);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    @(posedge clk); #1;

    run_a(1'b0, 1'b0, cyc);
    check("clean_busy_cycles", cyc, 256);
    check("clean_pass", pass_a, 1'b1);
    check("clean_err", err_a, 16'd0);

    run_a(1'b1, 1'b0, cyc);
    check("fault_busy_cycles", cyc, 256);
    check("fault_err", err_a, 16'd8);
    check("fault_pass", pass_a, 1'b0);

    run_a(1'b0, 1'b1, cyc);
    check("poke_busy_cycles", cyc, 256);
    check("poke_pass", pass_a, 1'b1);
    check("poke_err", err_a, 16'd0);

    manual_a = 1'b1; we_a = 1'b1; waddr_a = 6'd5; wdata_a = 1'b1; raddr_a = {8{6'd5}};
    @(posedge clk); #1;
    we_a = 1'b0;
    check("man_rd5", rdata_a, 8'hFF);
    check("man_done_kept", done_a, 1'b1);
    check("man_pass_kept", pass_a, 1'b1);
    raddr_a = {8{6'd6}};
    #1 check("man_rd6", rdata_a, 8'hFF);
    raddr_a = {8{6'd3}};
    #1 check("man_rd3", rdata_a, 8'h00);
    @(posedge clk); #1;
    manual_a = 1'b0;
    @(posedge clk); #1;

    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (100) @(posedge clk);
    #1 rst_n_a = 1'b0;
    #1;
    check("midrst_busy", busy_a, 1'b0);
    check("midrst_done", done_a, 1'b0);
    check("midrst_pass", pass_a, 1'b0);
    check("midrst_state", st_a, 2'd0);
    @(posedge clk); #1;
    rst_n_a = 1'b1;
    @(posedge clk); #1;
    run_a(1'b0, 1'b0, cyc);
    check("restart_busy_cycles", cyc, 256);
    check("restart_pass", pass_a, 1'b1);

    run_b(1'b0, cyc);
    check("b_busy_cycles", cyc, 64);
    check("b_pass", pass_b, 1'b1);
    check("b_err", err_b, 16'd0);
    run_b(1'b1, cyc);
    check("b_fault_busy_cycles", cyc, 64);
    check("b_fault_err", err_b, 16'd3);
    check("b_fault_pass", pass_b, 1'b0);

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_mport_bist.md
Name: dram_mport_bist

Overview:
Parametrised multi-port distributed-RAM block: one synchronous write port and NUM_RD asynchronous read ports on a shared 2^ADDR_W x DATA_W array, generalising the fixed 64x1, 8-port LUTRAM to any width, depth and port count. It has a built-in self-test FSM that fills the array with a pattern and its complement, and checks every read port against expected data. A manual mode gives direct switch-driven access. It sits in the feature test tops between the board switches/LEDs and the placer-visible distributed-RAM primitives.

Parameters:
ADDR_W, 6, address width; DEPTH = 2^ADDR_W words
DATA_W, 1, bits per word
NUM_RD, 8, number of read ports (1..8)

Ports:
clk  in  1  single clock; all writes and state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  BIST start, sampled in IDLE/DONE only
manual  in  1  1 = manual access mode, honoured in IDLE/DONE only
fault_inj  in  1  during FILL phase 0, invert the word written to address 0
man_we  in  1  manual write enable
man_waddr  in  ADDR_W  manual write address
man_wdata  in  DATA_W  manual write data
man_raddr  in  NUM_RD*ADDR_W  manual read addresses, port p at [p*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  read data, port p at [p*DATA_W +: DATA_W], combinational from array
busy  out  1  BIST running
done  out  1  BIST complete
pass  out  1  valid when done; 1 iff err_count == 0
err_count  out  16  saturating mismatch count

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, busy=0, done=0, pass=0, err_count=0, counters=0. Array contents are not cleared and are retained across reset.
- Array: write at posedge when write-enable is high. Reads are asynchronous: rdata follows address/array with no clock, so a port reading the write address sees new data after the edge.
- Address/data mux: manual=1 in IDLE/DONE -> man_* drive the ports. Otherwise the FSM drives them, and in IDLE/DONE with manual=0 the write enable is 0.
- FSM states: IDLE, FILL, CHECK, DONE. Phase bit ph in {0,1}.
- IDLE/DONE + start=1 + manual=0 -> FILL, ph=0, cnt=0, err_count=0, done=0, busy=1 from the next cycle. start is ignored when manual=1.
- Expected pattern: exp(a,ph) = low DATA_W bits of {a replicated} XOR {DATA_W{ph}}.
- FILL: write exp(cnt,ph) at address cnt, one word per cycle. With fault_inj=1, ph=0 and cnt=0, the data is inverted. After cnt=DEPTH-1: cnt wraps to 0 and the FSM goes to CHECK.
- CHECK: port p reads address (cnt+p) mod DEPTH. Each cycle err_count += number of ports with rdata != exp(addr_p,ph), saturating at 16'hFFFF. After cnt=DEPTH-1: if ph=0, go to FILL with ph=1; else go to DONE.
- DONE: busy=0, done=1, pass=(err_count==0). Outputs hold until the next start (restart) or reset. Manual writes in DONE do not alter done/pass/err_count.
- Total busy time is exactly 4*DEPTH cycles (256 at defaults). done rises on the edge after the last CHECK cycle.
- start, manual and fault_inj (outside the FILL ph=0 window) are ignored while busy.
- Reset mid-BIST: returns to IDLE immediately. A partly written array is left as-is.
- NUM_RD > DEPTH is not supported.

Test Plan:
- Defaults, reset, pulse start -> busy=1 for exactly 256 cycles, then done=1, pass=1, err_count=0.
- Defaults, fault_inj=1 through FILL phase 0 -> DONE with err_count=8 and pass=0.
- Manual: man_we=1, man_waddr=5, man_wdata=1, all man_raddr=5 -> after the edge all 8 rdata bits = 1; man_raddr=6 reads back the BIST phase-1 value exp(6,1)=1.
- Assert rst_n=0 at cycle 100 of BIST -> outputs 0 and IDLE immediately. Restart completes with pass=1 after 256 cycles.
- ADDR_W=4, DATA_W=4, NUM_RD=3 -> busy for 64 cycles, pass=1. With fault_inj, err_count=3.
- start asserted mid-BIST and manual=1 mid-BIST -> no effect on timing or result. A second start in DONE clears err_count and reruns.
